// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled UART receiver; optional parity via UART_RX_PARITY_EN
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 armed;
  logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM: advances only on sample ticks; strobes are single-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      armed      <= 1'b0;
      shift_reg  <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (sample_tick) begin
        case (state)
          IDLE: begin
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state    <= START;
              rx_busy  <= 1'b1;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == HALF_TICK) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                // Start bit did not hold to its mid-point: glitch
                state   <= IDLE;
                rx_busy <= 1'b0;
                armed   <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              state    <= IDLE;
              rx_busy  <= 1'b0;
              if (rx_s) begin
                rx_data <= shift_reg;
`ifdef UART_RX_PARITY_EN
                if ((^shift_reg ^ par_bit) != PARITY_ODD) parity_err <= 1'b1;
                else                                      rx_valid   <= 1'b1;
`else
                rx_valid <= 1'b1;
`endif
              end else begin
                // Low stop bit: require the line to go high before the next start
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (parity checks when UART_RX_PARITY_EN is defined)
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int BIT      = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick = 1'b0;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
  logic       parity_err;
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  typedef struct {
    int         kind;   // 0 valid, 1 frame error, 2 parity error
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_data = 8'h00;
  int         n_checks = 0;
  int         n_fail = 0;
  int         valid_count = 0;
  int         tcnt = 0;
  longint     cyc = 0;
  longint     last_valid_cyc = 0;
  longint     prev_valid_cyc = 0;
  logic       prev_strobe = 1'b0;

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_tick(sample_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    tcnt        <= (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
    sample_tick <= (tcnt == TICK_DIV - 1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // flip inverts the parity bit (parity builds only)
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip, input bit expect_it);
    exp_t e;
    if (expect_it) begin
      e.data = d;
      if (!stop) begin
        e.kind = 1;
        e.data = model_data;
      end else if (flip) begin
        e.kind = 2;
        model_data = d;
      end else begin
        e.kind = 0;
        model_data = d;
      end
      sb.push_back(e);
    end
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ flip;
    wait_clks(BIT);
`endif
    rx = stop;
    wait_clks(BIT);
    rx = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a strobe appears
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_strobe) check("strobe_width", int'(rx_valid) + int'(frame_err) + int'(parity_err), 0);
      if (rx_valid || frame_err || parity_err) begin
        int k;
        exp_t e;
        k = rx_valid ? 0 : (frame_err ? 1 : 2);
        check("strobe_exclusive", int'(rx_valid) + int'(frame_err) + int'(parity_err), 1);
        if (sb.size() == 0) begin
          check("unexpected_strobe", k, -1);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", k, e.kind);
          check("rx_data", rx_data, e.data);
        end
        if (rx_valid) begin
          valid_count++;
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
        end
      end
      prev_strobe = rx_valid || frame_err || parity_err;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  initial begin
    int exp_valids;
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_clks(5);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_rx_busy", rx_busy, 0);
    rst_n = 1'b1;
    wait_clks(2 * BIT);

    // Single frame 0xA5
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      begin
        wait_clks(5 * BIT);
        check("busy_mid_frame", rx_busy, 1);
      end
    join
    wait_clks(2 * BIT);
    check("busy_after_frame", rx_busy, 0);
    check("data_a5_held", rx_data, 8'hA5);
    exp_valids = 1;

    // Back-to-back 0x00, 0xFF
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    wait_clks(2 * BIT);
    exp_valids += 2;
    check("b2b_valid_count", valid_count, exp_valids);
    check("b2b_spacing", last_valid_cyc - prev_valid_cyc, FRAME_BITS * BIT);

    // 200 ns glitch on idle line
    rx = 1'b0;
    wait_clks(20);
    rx = 1'b1;
    check("glitch_busy", rx_busy, 1);
    wait_clks(BIT);
    check("glitch_idle", rx_busy, 0);
    check("glitch_data", rx_data, 8'hFF);

    // Framing error on 0x3C, line held low, then 0x55
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    rx = 1'b0;
    wait_clks(3 * BIT);
    check("stuck_low_ignored", rx_busy, 0);
    rx = 1'b1;
    wait_clks(2 * BIT);
    check("ferr_data_kept", rx_data, 8'hFF);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    wait_clks(2 * BIT);
    exp_valids += 1;
    check("data_55", rx_data, 8'h55);

    // Reset in bit 4 of 0x81
    rx = 1'b0;
    wait_clks(BIT);
    rx = 1'b1;
    wait_clks(BIT);
    rx = 1'b0;
    wait_clks(3 * BIT + BIT / 2);
    check("busy_before_reset", rx_busy, 1);
    rst_n = 1'b0;
    wait_clks(1);
    check("abort_rx_data", rx_data, 0);
    check("abort_rx_busy", rx_busy, 0);
    model_data = 8'h00;
    rx = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2 * BIT);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    wait_clks(2 * BIT);
    exp_valids += 1;
    check("data_81", rx_data, 8'h81);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_clks(2 * BIT);
    check("perr_data", rx_data, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    wait_clks(2 * BIT);
    exp_valids += 1;
`endif

    for (int i = 0; i < 20 * BIT && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("total_valids", valid_count, exp_valids);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
